// File: rtl/sym_gen_lfsr_pkg.sv
// Shared types and tables for the LFSR symbol generator.
// Optional build macro: SYMGEN_NO_REPEAT_EN (forbids two identical consecutive symbols).
package symgen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a} patterns for hex digits 0-F, dp off.
  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Folds a raw LFSR nibble into 0..num_syms-1. A single subtraction is
  // enough because num_syms is always more than half the index range.
  function automatic logic [3:0] map_idx(input logic [3:0] lfsr_low,
                                         input int unsigned num_syms);
    logic [4:0] v;
    v = {1'b0, lfsr_low};
    if (v >= 5'(num_syms)) v = v - 5'(num_syms);
    return v[3:0];
  endfunction

endpackage

// File: rtl/sym_gen_lfsr_if.sv
// Control/status bundle between the game controller and the symbol generator.
// Optional build macro: SYMGEN_NO_REPEAT_EN (no effect on this interface).
interface sym_gen_lfsr_if #(
  parameter int PERIOD_W  = 27,
  parameter int SYM_IDX_W = 4,
  parameter int CNT_W     = 8,
  parameter int LFSR_W    = 16
);
  logic                 genSym;
  logic [PERIOD_W-1:0]  symGenMax;
  logic [SYM_IDX_W-1:0] targetSym;
  logic                 seedLoad;
  logic [LFSR_W-1:0]    seed;
  logic                 generated;
  logic                 special;
  logic [7:0]           generatedSym;
  logic [SYM_IDX_W-1:0] symIdx;
  logic [CNT_W-1:0]     symCount;
  logic [CNT_W-1:0]     specialCount;
  logic                 done;

  modport master (
    output genSym, symGenMax, targetSym, seedLoad, seed,
    input  generated, special, generatedSym, symIdx, symCount, specialCount, done
  );

  modport slave (
    input  genSym, symGenMax, targetSym, seedLoad, seed,
    output generated, special, generatedSym, symIdx, symCount, specialCount, done
  );
endinterface

// File: rtl/sym_gen_lfsr_seg_enc.sv
// Symbol index to active-low 7-segment pattern, purely combinational.
// Optional build macro: SYMGEN_NO_REPEAT_EN (no effect here).
module sym_seg_enc
  import symgen_pkg::*;
#(
  parameter int SYM_IDX_W = 4
) (
  input  logic [SYM_IDX_W-1:0] idx,
  output logic [7:0]           seg
);

  assign seg = SEG_LUT[4'(idx)];

endmodule

// File: rtl/sym_gen_lfsr.sv
// Pseudo-random symbol generator for the symbol-counting game.
// Optional build macro: SYMGEN_NO_REPEAT_EN - when defined, a symbol equal to
// the previous one is bumped to the next index so repeats never occur.
//
// state | meaning
// IDLE  | waiting for genSym; seed loads accepted here only
// RUN   | game period, one symbol every max(symGenMax,1) clocks
// DONE  | MAX_SYMS symbols emitted, waiting for genSym to drop
module sym_gen_lfsr
  import symgen_pkg::*;
#(
  parameter int                PERIOD_W  = 27,
  parameter int                NUM_SYMS  = 10,
  parameter int                SYM_IDX_W = 4,
  parameter int                CNT_W     = 8,
  parameter int                MAX_SYMS  = 100,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400
) (
  input logic          Clk100M,
  input logic          resetN,
  sym_gen_lfsr_if.slave bus
);

  state_t               state;
  logic [PERIOD_W-1:0]  divider;
  logic [LFSR_W-1:0]    lfsr;
  logic                 gen_q, spec_q, done_q;
  logic [7:0]           seg_q;
  logic [SYM_IDX_W-1:0] idx_q;
  logic [CNT_W-1:0]     sym_cnt, spec_cnt;

  logic [PERIOD_W-1:0]  eff_max;
  logic                 terminal;
  logic [LFSR_W-1:0]    lfsr_step;
  logic [SYM_IDX_W-1:0] idx_map, idx_nxt;
  logic                 special_nxt;
  logic [7:0]           seg_nxt;

  // Period, LFSR advance and next-symbol selection for a potential emission.
  always_comb begin
    eff_max   = (bus.symGenMax == '0) ? PERIOD_W'(1) : bus.symGenMax;
    // >= rather than == so a shrinking period fires immediately instead of wrapping
    terminal  = (divider >= eff_max - PERIOD_W'(1));
    lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
    idx_map   = SYM_IDX_W'(map_idx(4'(lfsr_step[SYM_IDX_W-1:0]), NUM_SYMS));
    idx_nxt   = idx_map;
`ifdef SYMGEN_NO_REPEAT_EN
    if ((idx_map == idx_q) && (sym_cnt != '0))
      idx_nxt = (int'(idx_map) + 1 == NUM_SYMS) ? '0 : idx_map + SYM_IDX_W'(1);
`endif
    special_nxt = (idx_nxt == bus.targetSym);
  end

  sym_seg_enc #(.SYM_IDX_W(SYM_IDX_W)) u_seg_enc (
    .idx (idx_nxt),
    .seg (seg_nxt)
  );

  // Round FSM with divider, LFSR and all registered outputs.
  always_ff @(posedge Clk100M or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      divider  <= '0;
      lfsr     <= LFSR_W'(1);
      gen_q    <= 1'b0;
      spec_q   <= 1'b0;
      done_q   <= 1'b0;
      seg_q    <= SEG_BLANK;
      idx_q    <= '0;
      sym_cnt  <= '0;
      spec_cnt <= '0;
    end else begin
      gen_q  <= 1'b0;
      spec_q <= 1'b0;
      case (state)
        IDLE: begin
          // seed load takes the cycle; RUN entry waits until seedLoad drops
          if (bus.seedLoad) begin
            lfsr <= (bus.seed == '0) ? LFSR_W'(1) : bus.seed;
          end else if (bus.genSym) begin
            state    <= RUN;
            divider  <= '0;
            sym_cnt  <= '0;
            spec_cnt <= '0;
            seg_q    <= SEG_BLANK;
          end
        end
        RUN: begin
          if (!bus.genSym) begin
            state <= IDLE;
          end else if (terminal) begin
            divider <= '0;
            lfsr    <= lfsr_step;
            idx_q   <= idx_nxt;
            seg_q   <= seg_nxt;
            gen_q   <= 1'b1;
            spec_q  <= special_nxt;
            sym_cnt <= sym_cnt + CNT_W'(1);
            if (special_nxt && (spec_cnt != '1)) spec_cnt <= spec_cnt + CNT_W'(1);
            if (sym_cnt == CNT_W'(MAX_SYMS - 1)) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end else begin
            divider <= divider + PERIOD_W'(1);
          end
        end
        DONE: begin
          if (!bus.genSym) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.generated    = gen_q;
  assign bus.special      = spec_q;
  assign bus.done         = done_q;
  assign bus.generatedSym = seg_q;
  assign bus.symIdx       = idx_q;
  assign bus.symCount     = sym_cnt;
  assign bus.specialCount = spec_cnt;

endmodule

// File: tb/tb_sym_gen_lfsr.sv
// Directed bench for sym_gen_lfsr with a small LFSR/symbol reference model.
module tb_sym_gen_lfsr;

  localparam int NSYM = 10;

  logic Clk100M = 1'b0;
  logic resetN  = 1'b0;

  always #5 Clk100M = ~Clk100M;

  sym_gen_lfsr_if #(.PERIOD_W(27), .SYM_IDX_W(4), .CNT_W(8), .LFSR_W(16)) bus ();

  sym_gen_lfsr dut (
    .Clk100M (Clk100M),
    .resetN  (resetN),
    .bus     (bus)
  );

  logic [7:0] seg_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [15:0] m_lfsr;
  logic [3:0]  m_idx;
  int          m_cnt;
  int          m_spc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge Clk100M);
    #1;
  endtask

  function automatic logic [15:0] f_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [3:0] f_map(input logic [3:0] v);
    return (v >= 4'(NSYM)) ? v - 4'(NSYM) : v;
  endfunction

  task automatic check_reset(input string tag);
    check_val({tag, "_gen"},  32'(bus.generated),    32'd0);
    check_val({tag, "_spc"},  32'(bus.special),      32'd0);
    check_val({tag, "_done"}, 32'(bus.done),         32'd0);
    check_val({tag, "_seg"},  32'(bus.generatedSym), 32'hFF);
    check_val({tag, "_idx"},  32'(bus.symIdx),       32'd0);
    check_val({tag, "_cnt"},  32'(bus.symCount),     32'd0);
    check_val({tag, "_scnt"}, 32'(bus.specialCount), 32'd0);
  endtask

  // Expects per-1 quiet cycles then one emission; hit selects a matching target.
  task automatic run_sym(input int per, input bit hit);
    logic [15:0] nl;
    logic [3:0]  p;
    nl = f_step(m_lfsr);
    p  = f_map(nl[3:0]);
`ifdef SYMGEN_NO_REPEAT_EN
    if ((p == m_idx) && (m_cnt != 0)) p = (p == 4'(NSYM - 1)) ? 4'd0 : p + 4'd1;
`endif
    bus.targetSym = hit ? p : ((p == 4'(NSYM - 1)) ? 4'd0 : p + 4'd1);
    for (int i = 1; i < per; i++) begin
      tick;
      check_val("gen_gap", 32'(bus.generated), 32'd0);
      check_val("spc_gap", 32'(bus.special),   32'd0);
    end
    tick;
    m_lfsr = nl;
    m_idx  = p;
    m_cnt++;
    if (hit && m_spc < 255) m_spc++;
    check_val("gen_pulse", 32'(bus.generated),    32'd1);
    check_val("spc_pulse", 32'(bus.special),      32'(hit));
    check_val("sym_idx",   32'(bus.symIdx),       32'(p));
    check_val("sym_seg",   32'(bus.generatedSym), 32'(seg_tab[p]));
    check_val("sym_cnt",   32'(bus.symCount),     32'(m_cnt));
    check_val("spc_cnt",   32'(bus.specialCount), 32'(m_spc));
    check_val("idx_range", 32'(bus.symIdx < 4'(NSYM)), 32'd1);
  endtask

  initial begin
    int pulses;
    bus.genSym    = 1'b0;
    bus.symGenMax = '0;
    bus.targetSym = '0;
    bus.seedLoad  = 1'b0;
    bus.seed      = '0;
    m_lfsr = 16'h0001;
    m_idx  = '0;
    m_cnt  = 0;
    m_spc  = 0;

    repeat (3) tick;
    check_reset("rst_hold");
    resetN = 1'b1;
    tick;
    check_reset("rst_rel");

    // seeded run, period 5, alternating hit/miss targets
    bus.seed     = 16'hACE1;
    bus.seedLoad = 1'b1;
    tick;
    bus.seedLoad = 1'b0;
    m_lfsr = 16'hACE1;
    bus.symGenMax = 27'd5;
    bus.genSym    = 1'b1;
    tick;
    check_val("entry_seg", 32'(bus.generatedSym), 32'hFF);
    check_val("entry_cnt", 32'(bus.symCount),     32'd0);
    run_sym(5, 1'b1);
    run_sym(5, 1'b0);
    run_sym(5, 1'b1);
    run_sym(5, 1'b0);

    // period 0 behaves as 1
    bus.symGenMax = 27'd0;
    run_sym(1, 1'b0);
    run_sym(1, 1'b1);
    run_sym(1, 1'b0);

    // shrink 1000 -> 3 with divider at 500
    bus.symGenMax = 27'd1000;
    pulses = 0;
    repeat (500) begin
      tick;
      if (bus.generated) pulses++;
    end
    check_val("shrink_quiet", 32'(pulses), 32'd0);
    bus.symGenMax = 27'd3;
    run_sym(1, 1'b1);
    run_sym(3, 1'b0);
    run_sym(3, 1'b1);

    // drop genSym exactly on a terminal cycle
    tick;
    tick;
    bus.genSym = 1'b0;
    tick;
    check_val("abort_gen", 32'(bus.generated),    32'd0);
    check_val("abort_cnt", 32'(bus.symCount),     32'(m_cnt));
    check_val("abort_scn", 32'(bus.specialCount), 32'(m_spc));
    check_val("abort_idx", 32'(bus.symIdx),       32'(m_idx));
    check_val("abort_seg", 32'(bus.generatedSym), 32'(seg_tab[m_idx]));
    tick;
    check_val("abort_idle", 32'(bus.generated), 32'd0);

    // zero seed loaded together with genSym: load wins, RUN one cycle later
    bus.seed     = 16'h0000;
    bus.seedLoad = 1'b1;
    bus.genSym   = 1'b1;
    tick;
    check_val("seedgen_hold", 32'(bus.symCount), 32'(m_cnt));
    bus.seedLoad = 1'b0;
    tick;
    m_lfsr = 16'h0001;
    m_cnt  = 0;
    m_spc  = 0;
    check_val("reentry_cnt", 32'(bus.symCount),     32'd0);
    check_val("reentry_seg", 32'(bus.generatedSym), 32'hFF);

    // full round of 100 symbols at period 2
    bus.symGenMax = 27'd2;
    for (int i = 0; i < 100; i++) begin
      run_sym(2, (i % 7) == 0);
      if (i == 98) check_val("done_early", 32'(bus.done), 32'd0);
    end
    check_val("done_set", 32'(bus.done), 32'd1);
    pulses = 0;
    repeat (10) begin
      tick;
      if (bus.generated) pulses++;
    end
    check_val("done_quiet", 32'(pulses),        32'd0);
    check_val("done_hold",  32'(bus.done),      32'd1);
    check_val("done_cnt",   32'(bus.symCount),  32'd100);
    bus.genSym = 1'b0;
    tick;
    check_val("done_clear", 32'(bus.done), 32'd0);

`ifdef SYMGEN_NO_REPEAT_EN
    begin
      int reps;
      int total;
      logic [3:0] prev;
      bit have_prev;
      reps  = 0;
      total = 0;
      prev  = '0;
      bus.symGenMax = 27'd0;
      for (int r = 0; r < 100; r++) begin
        bus.genSym = 1'b1;
        tick;
        have_prev = 1'b0;
        for (int c = 0; c < 110; c++) begin
          tick;
          if (bus.generated) begin
            total++;
            if (have_prev && bus.symIdx == prev) reps++;
            prev = bus.symIdx;
            have_prev = 1'b1;
          end
        end
        bus.genSym = 1'b0;
        tick;
      end
      check_val("norep_total", 32'(total), 32'd10000);
      check_val("norep_reps",  32'(reps),  32'd0);
    end
`endif

    // async reset in the middle of a run
    bus.symGenMax = 27'd2;
    bus.genSym    = 1'b1;
    tick;
    repeat (5) tick;
    #2;
    resetN     = 1'b0;
    bus.genSym = 1'b0;
    #1;
    check_reset("async_rst");
    tick;
    resetN = 1'b1;
    pulses = 0;
    repeat (1000) begin
      tick;
      if (bus.generated) pulses++;
    end
    check_val("post_rst_quiet", 32'(pulses), 32'd0);
    check_reset("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
